serial_addsub: RTL and testbench

- Parametrised, bit-serial adder/subtractor for the SAP datapath.
- Successor to the gate-level half-adder: one full-adder bit-slice plus a carry flip-flop processes WIDTH-bit operands LSB-first, one bit per clock.
- Start/busy/done handshake and registered flags (carry, signed overflow, zero).
- Serves as the ALU add/sub engine when area matters more than latency.

---
 rtl/serial_addsub.sv | 159 +++++++++++++++
 tb/tb_serial_addsub.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : serial_addsub
//  Description : Bit-serial adder/subtractor. One full-adder slice plus a
//                carry flip-flop processes WIDTH-bit operands LSB-first, one
//                bit per clock, with a start/busy/done handshake and
//                registered carry, signed-overflow and zero flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             SUB,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW,
    output logic             ZERO
);

    // Counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice
    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             state_q,   state_d;
    logic [WIDTH-1:0]   a_sr_q,    a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,    b_sr_d;
    logic [WIDTH-1:0]   res_sr_q,  res_sr_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic               c_q,       c_d;
    logic               a_msb_q,   a_msb_d;
    logic               b_msb_q,   b_msb_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [WIDTH-1:0]   sum_q,     sum_d;
    logic               carry_q,   carry_d;
    logic               ovf_q,     ovf_d;
    logic               zero_q,    zero_d;

    // Full-adder bit-slice terms for the current LSB pair
    logic               bit_s;
    logic               bit_c;
    logic [WIDTH-1:0]   res_next;

    // Bit-slice arithmetic and the next-state / registered-output logic
    always_comb begin
        bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ c_q;
        bit_c    = (a_sr_q[0] & b_sr_q[0]) | (c_q & (a_sr_q[0] ^ b_sr_q[0]));
        res_next = {bit_s, res_sr_q[WIDTH-1:1]};

        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        busy_d   = busy_q;
        done_d   = 1'b0;          // DONE is a single-cycle pulse
        sum_d    = sum_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (START) begin
                    // Subtraction is A + ~B + 1: invert B and seed carry with 1
                    a_sr_d  = A;
                    b_sr_d  = SUB ? ~B : B;
                    c_d     = SUB;
                    cnt_d   = '0;
                    a_msb_d = A[WIDTH-1];
                    b_msb_d = B[WIDTH-1] ^ SUB;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                c_d      = bit_c;
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_next;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    // Last slice: publish result and flags in one shot
                    sum_d   = res_next;
                    carry_d = bit_c;
                    ovf_d   = (a_msb_q == b_msb_q) && (bit_s != a_msb_q);
                    zero_d  = (res_next == '0);
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any in-flight operation
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sum_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign SUM      = sum_q;
    assign CARRY    = carry_q;
    assign OVERFLOW = ovf_q;
    assign ZERO     = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_addsub
//  Description : Directed self-checking bench for serial_addsub (WIDTH=8 and
//                WIDTH=2 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_addsub;

    logic       clk;
    logic       rst;

    // WIDTH=8 instance signals
    logic       start8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, carry8, ovf8, zero8;
    logic [7:0] sum8;

    // WIDTH=2 instance signals
    logic       start2, sub2;
    logic [1:0] a2, b2;
    logic       busy2, done2, carry2, ovf2, zero2;
    logic [1:0] sum2;

    int errors = 0;
    int checks = 0;
    int lat;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .CLK(clk), .RST(rst), .START(start8), .SUB(sub8), .A(a8), .B(b8),
        .BUSY(busy8), .DONE(done8), .SUM(sum8), .CARRY(carry8),
        .OVERFLOW(ovf8), .ZERO(zero8)
    );

    serial_addsub #(.WIDTH(2)) u_dut2 (
        .CLK(clk), .RST(rst), .START(start2), .SUB(sub2), .A(a2), .B(b2),
        .BUSY(busy2), .DONE(done2), .SUM(sum2), .CARRY(carry2),
        .OVERFLOW(ovf2), .ZERO(zero2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue START on the 8-bit DUT and wait (bounded) for DONE; lat = edges after acceptance
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sub, output int n);
        a8 = a; b8 = b; sub8 = sub; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic expect8(input string tag, input int n, input int s, input logic c,
                           input logic v, input logic z);
        check({tag, ".lat"},   n, 8);
        check({tag, ".done"},  {31'd0, done8}, 1);
        check({tag, ".busy"},  {31'd0, busy8}, 0);
        check({tag, ".sum"},   {24'd0, sum8}, s);
        check({tag, ".carry"}, {31'd0, carry8}, {31'd0, c});
        check({tag, ".ovf"},   {31'd0, ovf8}, {31'd0, v});
        check({tag, ".zero"},  {31'd0, zero8}, {31'd0, z});
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0; sub8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst.busy",  {31'd0, busy8}, 0);
        check("rst.done",  {31'd0, done8}, 0);
        check("rst.sum",   {24'd0, sum8}, 0);
        check("rst.carry", {31'd0, carry8}, 0);
        check("rst.ovf",   {31'd0, ovf8}, 0);
        check("rst.zero",  {31'd0, zero8}, 0);
        check("rst2.busy", {31'd0, busy2}, 0);

        // 5 + 3 = 8; busy right after acceptance
        a8 = 8'd5; b8 = 8'd3; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("add53.busy_early", {31'd0, busy8}, 1);
        lat = 0;
        while (!done8 && lat < 20) begin
            check("add53.sum_hold", {24'd0, sum8}, 0);
            tick();
            lat++;
        end
        expect8("add53", lat, 8, 1'b0, 1'b0, 1'b0);
        tick();
        check("add53.done_pulse", {31'd0, done8}, 0);
        check("add53.sum_kept", {24'd0, sum8}, 8);

        run8(8'd200, 8'd100, 1'b0, lat);
        expect8("add200_100", lat, 44, 1'b1, 1'b0, 1'b0);
        tick();
        run8(8'd127, 8'd1, 1'b0, lat);
        expect8("add127_1", lat, 128, 1'b0, 1'b1, 1'b0);
        tick();
        run8(8'd128, 8'd1, 1'b1, lat);
        expect8("sub128_1", lat, 127, 1'b1, 1'b1, 1'b0);
        tick();
        run8(8'd5, 8'd7, 1'b1, lat);
        expect8("sub5_7", lat, 254, 1'b0, 1'b0, 1'b0);
        tick();
        run8(8'd9, 8'd9, 1'b1, lat);
        expect8("sub9_9", lat, 0, 1'b1, 1'b0, 1'b1);
        tick();

        // 1 + 1 with an ignored START (50+50) at cycle 3
        a8 = 8'd1; b8 = 8'd1; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        a8 = 8'd50; b8 = 8'd50; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("ign.busy", {31'd0, busy8}, 1);
        lat = 3;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        expect8("ign", lat, 2, 1'b0, 1'b0, 1'b0);

        // START in the DONE cycle is accepted: 10 + 20
        a8 = 8'd10; b8 = 8'd20; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        check("b2b.done_low", {31'd0, done8}, 0);
        check("b2b.busy",     {31'd0, busy8}, 1);
        check("b2b.sum_prev", {24'd0, sum8}, 2);
        lat = 0;
        while (!done8 && lat < 20) begin
            tick();
            lat++;
        end
        expect8("b2b", lat, 30, 1'b0, 1'b0, 1'b0);
        tick();

        // 255 + 255 aborted by reset at cycle 4
        a8 = 8'd255; b8 = 8'd255; sub8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.busy",  {31'd0, busy8}, 0);
        check("abort.done",  {31'd0, done8}, 0);
        check("abort.sum",   {24'd0, sum8}, 0);
        check("abort.carry", {31'd0, carry8}, 0);
        check("abort.ovf",   {31'd0, ovf8}, 0);
        check("abort.zero",  {31'd0, zero8}, 0);
        for (int i = 0; i < 12; i++) begin
            check("abort.no_done", {31'd0, done8}, 0);
            tick();
        end
        run8(8'd1, 8'd2, 1'b0, lat);
        expect8("after_abort", lat, 3, 1'b0, 1'b0, 1'b0);
        tick();

        // WIDTH=2: 3 + 3 = 2 with carry, done 2 edges after acceptance
        a2 = 2'd3; b2 = 2'd3; sub2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        check("w2.busy", {31'd0, busy2}, 1);
        lat = 0;
        while (!done2 && lat < 20) begin
            tick();
            lat++;
        end
        check("w2.lat",   lat, 2);
        check("w2.done",  {31'd0, done2}, 1);
        check("w2.sum",   {30'd0, sum2}, 2);
        check("w2.carry", {31'd0, carry2}, 1);
        check("w2.ovf",   {31'd0, ovf2}, 0);
        check("w2.zero",  {31'd0, zero2}, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
